// File: rtl/mem_wb_skid_stage.sv
// MEM->WB elastic pipeline stage: main + skid register pair, writeback mux,
// forwarding tap for the hazard unit and a saturating back-pressure counter.
module mem_wb_skid_stage #(
   parameter int DATA_W            = 32,
   parameter int RADDR_W           = 5,
   parameter int ZERO_REG_SUPPRESS = 1,
   parameter int STALL_CNT_W       = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_regwrite,
   input  logic                   in_memtoreg,
   input  logic [DATA_W-1:0]      in_mem_data,
   input  logic [DATA_W-1:0]      in_alu_result,
   input  logic [RADDR_W-1:0]     in_rd,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_regwrite,
   output logic                   out_memtoreg,
   output logic [DATA_W-1:0]      out_mem_data,
   output logic [DATA_W-1:0]      out_alu_result,
   output logic [RADDR_W-1:0]     out_rd,
   output logic                   wb_we,
   output logic [RADDR_W-1:0]     wb_addr,
   output logic [DATA_W-1:0]      wb_data,
   output logic                   fwd_valid,
   output logic [RADDR_W-1:0]     fwd_rd,
   output logic [DATA_W-1:0]      fwd_data,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   localparam int PL_W = 2 + 2 * DATA_W + RADDR_W;

   logic [PL_W-1:0]        w_in_pl;
   logic [PL_W-1:0]        r_main_pl;
   logic [PL_W-1:0]        r_skid_pl;
   logic                   r_main_valid;
   logic                   r_skid_valid;
   logic [STALL_CNT_W-1:0] r_stall_cnt;
   logic                   w_acc;
   logic                   w_pop;
   logic                   w_rd_ok;
   logic                   w_stall;

   assign w_in_pl = {in_regwrite, in_memtoreg, in_mem_data, in_alu_result, in_rd};
   assign {out_regwrite, out_memtoreg, out_mem_data, out_alu_result, out_rd} = r_main_pl;

   // in_ready depends only on the skid flag, which breaks the out_ready->in_ready path
   assign in_ready  = !r_skid_valid;
   assign out_valid = r_main_valid;
   assign w_acc     = in_valid & !r_skid_valid;
   assign w_pop     = r_main_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
         r_main_pl    <= '0;
         r_skid_pl    <= '0;
      end else if (flush) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (!r_main_valid) begin
         if (w_acc) begin
            r_main_pl    <= w_in_pl;
            r_main_valid <= 1'b1;
         end
      end else if (w_pop) begin
         if (r_skid_valid) begin
            r_main_pl    <= r_skid_pl;
            r_skid_valid <= 1'b0;
         end else if (w_acc) begin
            r_main_pl    <= w_in_pl;
         end else begin
            r_main_valid <= 1'b0;
         end
      end else if (w_acc) begin
         r_skid_pl    <= w_in_pl;
         r_skid_valid <= 1'b1;
      end
   end

   assign w_stall = r_main_valid & !out_ready & (r_stall_cnt != {STALL_CNT_W{1'b1}});

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (w_stall) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign stall_cnt = r_stall_cnt;

   // Writes to x0 are suppressed both for the register file and for forwarding
   assign w_rd_ok   = (ZERO_REG_SUPPRESS == 0) || (out_rd != '0);
   assign wb_data   = out_memtoreg ? out_mem_data : out_alu_result;
   assign wb_addr   = out_rd;
   assign wb_we     = w_pop & out_regwrite & w_rd_ok;
   assign fwd_valid = r_main_valid & out_regwrite & w_rd_ok;
   assign fwd_rd    = out_rd;
   assign fwd_data  = wb_data;

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Scoreboard bench for mem_wb_skid_stage: a capacity-2 FIFO model predicts the
// head entry, handshake flags and stall counter for two parameterisations.
module tb_mem_wb_skid_stage;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_regwrite = 1'b0;
   logic          in_memtoreg = 1'b0;
   logic [DW-1:0] in_mem_data = '0;
   logic [DW-1:0] in_alu_result = '0;
   logic [AW-1:0] in_rd = '0;
   logic          out_ready = 1'b0;

   logic          a_in_ready, a_out_valid, a_out_regwrite, a_out_memtoreg;
   logic [DW-1:0] a_out_mem_data, a_out_alu_result, a_wb_data, a_fwd_data;
   logic [AW-1:0] a_out_rd, a_wb_addr, a_fwd_rd;
   logic          a_wb_we, a_fwd_valid;
   logic [3:0]    a_stall_cnt;

   logic          b_in_ready, b_out_valid, b_out_regwrite, b_out_memtoreg;
   logic [DW-1:0] b_out_mem_data, b_out_alu_result, b_wb_data, b_fwd_data;
   logic [AW-1:0] b_out_rd, b_wb_addr, b_fwd_rd;
   logic          b_wb_we, b_fwd_valid;
   logic [15:0]   b_stall_cnt;

   mem_wb_skid_stage #(.DATA_W(DW), .RADDR_W(AW), .ZERO_REG_SUPPRESS(1), .STALL_CNT_W(4)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg), .in_mem_data(in_mem_data),
      .in_alu_result(in_alu_result), .in_rd(in_rd), .out_valid(a_out_valid), .out_ready(out_ready),
      .out_regwrite(a_out_regwrite), .out_memtoreg(a_out_memtoreg), .out_mem_data(a_out_mem_data),
      .out_alu_result(a_out_alu_result), .out_rd(a_out_rd), .wb_we(a_wb_we), .wb_addr(a_wb_addr),
      .wb_data(a_wb_data), .fwd_valid(a_fwd_valid), .fwd_rd(a_fwd_rd), .fwd_data(a_fwd_data),
      .stall_cnt(a_stall_cnt));

   mem_wb_skid_stage #(.DATA_W(DW), .RADDR_W(AW), .ZERO_REG_SUPPRESS(0), .STALL_CNT_W(16)) dut_nz (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg), .in_mem_data(in_mem_data),
      .in_alu_result(in_alu_result), .in_rd(in_rd), .out_valid(b_out_valid), .out_ready(out_ready),
      .out_regwrite(b_out_regwrite), .out_memtoreg(b_out_memtoreg), .out_mem_data(b_out_mem_data),
      .out_alu_result(b_out_alu_result), .out_rd(b_out_rd), .wb_we(b_wb_we), .wb_addr(b_wb_addr),
      .wb_data(b_wb_data), .fwd_valid(b_fwd_valid), .fwd_rd(b_fwd_rd), .fwd_data(b_fwd_data),
      .stall_cnt(b_stall_cnt));

   always #5 clk = ~clk;

   typedef struct {
      bit            rw;
      bit            m2r;
      logic [DW-1:0] md;
      logic [DW-1:0] alu;
      logic [AW-1:0] rd;
   } ent_t;

   ent_t exp_q[$];
   int   cnt_a = 0;
   int   cnt_b = 0;
   bit   started = 1'b0;
   bit   pop_pending = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: the stage behaves as an in-order queue holding at most two entries
   always @(posedge clk) begin
      int   n_before;
      ent_t e;
      n_before = exp_q.size() + (pop_pending ? 1 : 0);
      pop_pending = 1'b0;
      if (rst) begin
         exp_q.delete();
         cnt_a = 0;
         cnt_b = 0;
         started = 1'b1;
      end else begin
         if (n_before > 0 && !out_ready) begin
            if (cnt_a < 15)    cnt_a++;
            if (cnt_b < 65535) cnt_b++;
         end
         if (flush) begin
            exp_q.delete();
         end else if (in_valid && n_before < 2) begin
            e.rw  = in_regwrite;
            e.m2r = in_memtoreg;
            e.md  = in_mem_data;
            e.alu = in_alu_result;
            e.rd  = in_rd;
            exp_q.push_back(e);
         end
      end
   end

   // Monitor: compares the head entry and pops it when the consumer takes it
   always @(negedge clk) begin
      ent_t          h;
      logic [DW-1:0] d;
      bit            pop;
      if (started) begin
         chk("out_valid", a_out_valid, exp_q.size() > 0);
         chk("in_ready", a_in_ready, exp_q.size() < 2);
         chk("stall_cnt", a_stall_cnt, cnt_a);
         chk("nz_out_valid", b_out_valid, exp_q.size() > 0);
         chk("nz_in_ready", b_in_ready, exp_q.size() < 2);
         chk("nz_stall_cnt", b_stall_cnt, cnt_b);
         if (exp_q.size() > 0) begin
            h   = exp_q[0];
            d   = h.m2r ? h.md : h.alu;
            pop = out_ready;
            chk("out_rd", a_out_rd, h.rd);
            chk("wb_addr", a_wb_addr, h.rd);
            chk("wb_data", a_wb_data, d);
            chk("fwd_rd", a_fwd_rd, h.rd);
            chk("fwd_data", a_fwd_data, d);
            chk("fwd_valid", a_fwd_valid, h.rw && h.rd != 0);
            chk("wb_we", a_wb_we, pop && h.rw && h.rd != 0);
            chk("nz_wb_data", b_wb_data, d);
            chk("nz_fwd_valid", b_fwd_valid, h.rw);
            chk("nz_wb_we", b_wb_we, pop && h.rw);
            if (pop) begin
               void'(exp_q.pop_front());
               pop_pending = 1'b1;
            end
         end else begin
            chk("idle_wb_we", a_wb_we, 0);
            chk("idle_fwd_valid", a_fwd_valid, 0);
            chk("nz_idle_wb_we", b_wb_we, 0);
         end
      end
   end

   task automatic drive(input bit v, input bit rw, input bit m2r, input logic [DW-1:0] md,
                        input logic [DW-1:0] alu, input logic [AW-1:0] rd, input bit ordy,
                        input bit fl);
      in_valid      = v;
      in_regwrite   = rw;
      in_memtoreg   = m2r;
      in_mem_data   = md;
      in_alu_result = alu;
      in_rd         = rd;
      out_ready     = ordy;
      flush         = fl;
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input bit ordy, input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, '0, '0, ordy, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      chk("rst_wb_data", a_wb_data, 0);
      chk("rst_out_rd", a_out_rd, 0);
      chk("rst_out_alu", a_out_alu_result, 0);
      idle(1'b1, 2);

      for (int k = 1; k <= 8; k++)
         drive(1'b1, 1'b1, k[0], 32'hA000_0000 + k, 32'h0000_1000 + k, k[AW-1:0], 1'b1, 1'b0);
      idle(1'b1, 2);

      drive(1'b1, 1'b1, 1'b0, 32'hA000_0003, 32'h0000_1003, 5'd3, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 32'hA000_0004, 32'h0000_1004, 5'd4, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         drive(1'b1, 1'b1, 1'b1, 32'hA000_0007, 32'h0000_1007, 5'd7, 1'b0, 1'b0);
      idle(1'b1, 3);

      drive(1'b1, 1'b1, 1'b0, 32'hA000_000A, 32'h0000_100A, 5'd10, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 32'hA000_000B, 32'h0000_100B, 5'd11, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 32'hA000_0009, 32'h0000_1009, 5'd9, 1'b0, 1'b1);
      idle(1'b1, 3);

      drive(1'b1, 1'b1, 1'b0, 32'hA000_000C, 32'h0000_100C, 5'd12, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 32'hA000_000D, 32'h0000_100D, 5'd13, 1'b0, 1'b0);
      rst = 1'b1;
      idle(1'b0, 1);
      rst = 1'b0;
      chk("midrst_wb_data", a_wb_data, 0);
      chk("midrst_out_rd", a_out_rd, 0);
      idle(1'b1, 2);

      drive(1'b1, 1'b1, 1'b0, 32'hA000_0000, 32'h0000_1000, 5'd0, 1'b1, 1'b0);
      idle(1'b1, 2);

      for (int i = 0; i < 400; i++) begin
         rst = ($urandom % 97) == 0;
         drive(($urandom % 4) != 0, $urandom % 2, $urandom % 2, $urandom, $urandom,
               5'($urandom % 8), ($urandom % 3) != 0, ($urandom % 20) == 0);
      end
      rst = 1'b0;
      idle(1'b1, 3);

      drive(1'b1, 1'b1, 1'b0, 32'hA000_0005, 32'h0000_1005, 5'd5, 1'b0, 1'b0);
      idle(1'b0, 20);
      chk("stall_sat", a_stall_cnt, 15);
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
      idle(1'b0, 1);
      chk("stall_after_flush", a_stall_cnt, 15);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_wb_skid_stage.md
Name: mem_wb_skid_stage

Overview:
- Parametrised successor to the MEM/WB pipeline register.
- Elastic MEM->WB stage: valid/ready handshake with a 2-entry skid buffer (main + skid), so there is no combinational path from out_ready to in_ready.
- Adds synchronous flush, the MemtoReg writeback mux, and a forwarding tap for the hazard unit.
- Adds a saturating back-pressure counter for performance monitoring.

Parameters:
- DATA_W, 32, width of memory read data, ALU result and writeback data.
- RADDR_W, 5, register-file address width.
- ZERO_REG_SUPPRESS, 1, when 1 the stage never asserts writes to register address 0.
- STALL_CNT_W, 16, width of the back-pressure cycle counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  MEM stage presents an entry
- in_ready  out  1  stage can accept; registered, equals !skid_valid
- in_regwrite  in  1  entry writes the register file
- in_memtoreg  in  1  1 selects memory data, 0 selects ALU result
- in_mem_data  in  DATA_W  data-memory read data
- in_alu_result  in  DATA_W  ALU result / memory address
- in_rd  in  RADDR_W  destination register
- out_valid  out  1  head entry valid
- out_ready  in  1  WB consumer accepts head
- out_regwrite  out  1  head regwrite
- out_memtoreg  out  1  head memtoreg
- out_mem_data  out  DATA_W  head memory data
- out_alu_result  out  DATA_W  head ALU result
- out_rd  out  RADDR_W  head destination
- wb_we  out  1  register-file write enable (combinational)
- wb_addr  out  RADDR_W  equals out_rd
- wb_data  out  DATA_W  out_memtoreg ? out_mem_data : out_alu_result
- fwd_valid  out  1  out_valid & out_regwrite & (rd!=0 or !ZERO_REG_SUPPRESS)
- fwd_rd  out  RADDR_W  equals out_rd
- fwd_data  out  DATA_W  equals wb_data
- stall_cnt  out  STALL_CNT_W  cycles with out_valid & !out_ready, saturating

Behaviour:
- Reset (rst=1 at posedge):
  - main_valid=0, skid_valid=0, so out_valid=0 and in_ready=1.
  - All payload registers =0, so every out_*/wb_*/fwd_* reads 0 and wb_we=0.
  - stall_cnt=0.
  - rst dominates flush and all handshakes.
- Definitions: acc = in_valid & in_ready; pop = out_valid & out_ready.
- Head: out_* always driven from main registers; out_valid = main_valid.
- Clocked updates (when !rst and !flush):
  - main empty & acc: main <= input. Latency is 1 cycle, input at edge N appears on out_* after edge N.
  - main full & pop & !skid_valid & acc: main <= input.
  - main full & pop & skid_valid: main <= skid, skid_valid <= 0. in_ready was 0, so nothing is accepted.
  - main full & !pop & acc: skid <= input, skid_valid <= 1. in_ready falls next cycle.
  - main full & pop & !acc & !skid_valid: main_valid <= 0.
- Ordering: entries leave in acceptance order. No duplication or loss except on flush.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- Flush (flush=1 at posedge, !rst):
  - main_valid and skid_valid <= 0; an entry accepted in the same cycle is discarded.
  - Payload registers hold their values.
  - A pop in the flush cycle still completes: wb_we is combinational that cycle.
  - in_ready=1 on the next cycle.
- wb_we = pop & out_regwrite & !(ZERO_REG_SUPPRESS & out_rd==0).
- stall_cnt:
  - Increments when out_valid & !out_ready.
  - Holds at 2^STALL_CNT_W-1.
  - Not cleared by flush; only rst clears it.
- in_ready is a pure register output. No combinational input->output paths except wb_we, wb_data, and fwd_* derived from registered state and out_ready.

Test Plan:
- Reset, then rst=0 -> out_valid=0, in_ready=1, wb_data=0, stall_cnt=0. Assert rst for 1 cycle mid-stream with 2 entries held -> next cycle out_valid=0, in_ready=1.
- Stream in_valid=1, out_ready=1, in_rd=1..8, memtoreg alternating, mem_data=0xA000_000k, alu=0x0000_100k -> out_rd=1..8 one cycle later in order. wb_data alternates 0xA000_0001, 0x0000_1002, ... and wb_we=1 every cycle.
- Accept rd=3, then rd=4 with out_ready=0 -> in_ready=0 after the second entry and stall_cnt counts 1,2,3. Raise out_ready -> rd=3 then rd=4 pop on consecutive cycles, then in_ready=1.
- Hold 2 entries and pulse flush with in_valid=1, rd=9 -> next cycle out_valid=0, in_ready=1, rd=9 never appears, wb_we=0.
- in_regwrite=1, in_rd=0, ZERO_REG_SUPPRESS=1 -> pop occurs but wb_we=0 and fwd_valid=0. With ZERO_REG_SUPPRESS=0 -> wb_we=1.
- STALL_CNT_W=4 with out_valid=1, out_ready=0 for 20 cycles -> stall_cnt saturates at 15. Flush -> stall_cnt stays 15.
